// File: rtl/mc_port_arbiter.sv
// Round-robin share of one memory-controller front-end; tag FIFO routes completions (MC_ARB_PERF_CNT_EN adds grant counters).
// Latency: request to mc_* is combinational (0 cycles); completion to rsp_valid is 1 cycle.
// Backpressure: req_ready stays low while mc_busy is high or TAG_DEPTH requests are outstanding.
module mc_port_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 30,
   parameter int TAG_DEPTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req_valid,
   output logic [NUM_PORTS-1:0]            req_ready,
   input  logic [NUM_PORTS-1:0]            req_type,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
   output logic [NUM_PORTS-1:0]            rsp_valid,
   output logic                            rsp_type,
   output logic [DATA_WIDTH-1:0]           rsp_data,
   input  logic                            mc_busy,
   output logic                            mc_valid,
   output logic                            mc_type,
   output logic [ADDR_WIDTH-1:0]           mc_addr,
   output logic [DATA_WIDTH-1:0]           mc_data,
   input  logic                            mc_write_done,
   input  logic                            mc_read_done,
   input  logic [DATA_WIDTH-1:0]           mc_rdata,
   output logic [$clog2(TAG_DEPTH):0]      outstanding,
   output logic                            err_sticky,
   output logic [NUM_PORTS*16-1:0]         perf_grant_cnt
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int TW = $clog2(TAG_DEPTH);
   localparam int CW = TW + 1;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant;
   logic          found;
   logic          can_issue;
   logic          cpl;
   logic          push;
   logic          pop;
   logic          err_set;
   logic [PW:0]   tag_mem [TAG_DEPTH];
   logic [TW-1:0] wr_ptr;
   logic [TW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [PW-1:0] tag_port;
   logic          tag_type;

   // First valid port at or after rr_ptr, wrapping modulo NUM_PORTS.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_PORTS;
         if (!found && req_valid[PW'(idx)]) begin
            found = 1'b1;
            grant = PW'(idx);
         end
      end
   end

   assign can_issue = !mc_busy && (count < CW'(TAG_DEPTH)) && (|req_valid);
   assign push      = can_issue;

   always_comb begin
      req_ready = '0;
      mc_valid  = 1'b0;
      mc_type   = 1'b0;
      mc_addr   = '0;
      mc_data   = '0;
      if (can_issue) begin
         req_ready = NUM_PORTS'(1) << grant;
         mc_valid  = 1'b1;
         mc_type   = req_type[grant];
         mc_addr   = req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
         mc_data   = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign {tag_port, tag_type} = tag_mem[rd_ptr];

   // Simultaneous strobes still retire exactly one entry; empty-FIFO completions retire nothing.
   assign cpl     = mc_write_done | mc_read_done;
   assign pop     = cpl && (count != '0);
   assign err_set = (cpl && (count == '0))
                 || (mc_write_done && mc_read_done)
                 || (pop && (mc_write_done != tag_type));

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= {grant, req_type[grant]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rsp_valid  <= '0;
         rsp_type   <= 1'b0;
         rsp_data   <= '0;
         err_sticky <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + TW'(1);
            rr_ptr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + TW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
         rsp_valid <= pop ? (NUM_PORTS'(1) << tag_port) : '0;
         if (pop) begin
            rsp_type <= tag_type;
            rsp_data <= mc_rdata;
         end
         if (err_set) err_sticky <= 1'b1;
      end
   end

   assign outstanding = count;

`ifdef MC_ARB_PERF_CNT_EN
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_perf
      logic [15:0] cnt;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) cnt <= '0;
         else if (push && (grant == PW'(p)) && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
      end
      assign perf_grant_cnt[p*16 +: 16] = cnt;
   end
`else
   assign perf_grant_cnt = '0;
`endif

endmodule
